// File: rtl/shift_rotate_pipe.sv
// Pipelined log barrel shifter (SLL/ROL/SRL/ROR/SRA) with valid/ready on both sides.
// Optional macro SHROT_CARRY_EN adds the o_carry output and its pipeline storage.
module shift_rotate_pipe #(
    parameter int WIDTH     = 16,
    parameter bit PIPELINED = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               choice,
    input  logic [WIDTH-1:0]         i0,
    input  logic [$clog2(WIDTH)-1:0] shift_by,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         o,
    output logic                     o_zero
`ifdef SHROT_CARRY_EN
    ,
    output logic                     o_carry
`endif
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [2:0] op, input int amt);
        case (op)
            OP_SLL:  shift_step = d << amt;
            OP_ROL:  shift_step = (d << amt) | (d >> (WIDTH - amt));
            OP_SRL:  shift_step = d >> amt;
            OP_ROR:  shift_step = (d >> amt) | (d << (WIDTH - amt));
            OP_SRA:  shift_step = $signed(d) >>> amt;
            default: shift_step = d;
        endcase
    endfunction

`ifdef SHROT_CARRY_EN
    // Last bit out depends only on the original operand and the full amount.
    function automatic logic carry_of(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                      input logic [SHW-1:0] sh);
        carry_of = 1'b0;
        if (sh != '0) begin
            case (op)
                OP_SLL, OP_ROL:         carry_of = d[~sh + SHW'(1)];
                OP_SRL, OP_SRA, OP_ROR: carry_of = d[sh - SHW'(1)];
                default:                carry_of = 1'b0;
            endcase
        end
    endfunction
`endif

    logic adv;
    logic out_valid_q, o_zero_q, o_zero_d;
    logic [WIDTH-1:0] o_q, o_d;

    // A stall freezes the whole pipe; bubbles advance like operations.
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;

    genvar k;
    for (k = 0; k < SHW; k++) begin : g_stg
        logic [WIDTH-1:0] d_in, d_res;
        logic [2:0]       op_in;
        logic [SHW-1:k]   sh_in;
        logic             v_in;
`ifdef SHROT_CARRY_EN
        logic             cy_in;
`endif
        if (k == 0) begin : g_src
            assign d_in  = i0;
            assign op_in = choice;
            assign sh_in = shift_by;
            assign v_in  = in_valid && in_ready;
`ifdef SHROT_CARRY_EN
            assign cy_in = carry_of(i0, choice, shift_by);
`endif
        end else if (PIPELINED) begin : g_reg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d_in  <= '0;
                    op_in <= '0;
                    sh_in <= '0;
                    v_in  <= 1'b0;
`ifdef SHROT_CARRY_EN
                    cy_in <= 1'b0;
`endif
                end else if (adv) begin
                    d_in  <= g_stg[k-1].d_res;
                    op_in <= g_stg[k-1].op_in;
                    sh_in <= g_stg[k-1].sh_in[SHW-1:k];
                    v_in  <= g_stg[k-1].v_in;
`ifdef SHROT_CARRY_EN
                    cy_in <= g_stg[k-1].cy_in;
`endif
                end
            end
        end else begin : g_comb
            assign d_in  = g_stg[k-1].d_res;
            assign op_in = g_stg[k-1].op_in;
            assign sh_in = g_stg[k-1].sh_in[SHW-1:k];
            assign v_in  = g_stg[k-1].v_in;
`ifdef SHROT_CARRY_EN
            assign cy_in = g_stg[k-1].cy_in;
`endif
        end

        assign d_res = sh_in[k] ? shift_step(d_in, op_in, 2**k) : d_in;
    end

    // Bubbles load zeros so an idle output reads o=0, o_zero=0.
    assign o_d      = g_stg[SHW-1].v_in ? g_stg[SHW-1].d_res : '0;
    assign o_zero_d = g_stg[SHW-1].v_in && (g_stg[SHW-1].d_res == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            o_q         <= '0;
            o_zero_q    <= 1'b0;
        end else if (adv) begin
            out_valid_q <= g_stg[SHW-1].v_in;
            o_q         <= o_d;
            o_zero_q    <= o_zero_d;
        end
    end

`ifdef SHROT_CARRY_EN
    logic o_carry_q;
    always_ff @(posedge clk) begin
        if (!rst_n)   o_carry_q <= 1'b0;
        else if (adv) o_carry_q <= g_stg[SHW-1].v_in && g_stg[SHW-1].cy_in;
    end
    assign o_carry = o_carry_q;
`endif

    assign out_valid = out_valid_q;
    assign o         = o_q;
    assign o_zero    = o_zero_q;
endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Bench for shift_rotate_pipe: directed vectors plus a queue-based reference model
// checked every cycle on a pipelined and a single-register instance.
module tb_shift_rotate_pipe;
    localparam int W   = 16;
    localparam int SHW = 4;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, o_zero;
    logic [2:0] choice;
    logic [W-1:0] i0, o;
    logic [SHW-1:0] shift_by;
    logic in_valid0, in_ready0, out_valid0, out_ready0, o_zero0;
    logic [W-1:0] o0;
`ifdef SHROT_CARRY_EN
    logic o_carry, o_carry0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] o;
        logic         z;
        logic         c;
    } exp_t;
    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;

    shift_rotate_pipe #(.WIDTH(W), .PIPELINED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .choice(choice), .i0(i0), .shift_by(shift_by), .out_valid(out_valid),
        .out_ready(out_ready), .o(o), .o_zero(o_zero)
`ifdef SHROT_CARRY_EN
        , .o_carry(o_carry)
`endif
    );

    shift_rotate_pipe #(.WIDTH(W), .PIPELINED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .choice(choice), .i0(i0), .shift_by(shift_by), .out_valid(out_valid0),
        .out_ready(out_ready0), .o(o0), .o_zero(o_zero0)
`ifdef SHROT_CARRY_EN
        , .o_carry(o_carry0)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: whole-amount shift/rotate straight from the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] d, input int s);
        exp_t r;
        logic [2*W-1:0] dd;
        r.o = d;
        r.c = 1'b0;
        case (op)
            3'b000: begin r.o = d << s; if (s > 0) r.c = d[W-s]; end
            3'b001: begin dd = {d, d} << s; r.o = dd[2*W-1:W]; if (s > 0) r.c = r.o[0]; end
            3'b010: begin r.o = d >> s; if (s > 0) r.c = d[s-1]; end
            3'b011: begin dd = {d, d} >> s; r.o = dd[W-1:0]; if (s > 0) r.c = r.o[W-1]; end
            3'b100: begin
                for (int i = 0; i < W; i++) r.o[i] = (i + s < W) ? d[i+s] : d[W-1];
                if (s > 0) r.c = d[s-1];
            end
            default: r.o = d;
        endcase
        r.z = (r.o == '0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out_valid) begin
                if (q1.size() == 0) chk("p1_unexpected_valid", out_valid, 1'b0);
                else begin
                    chk("p1_model_o", o, q1[0].o);
                    chk("p1_model_zero", o_zero, q1[0].z);
`ifdef SHROT_CARRY_EN
                    chk("p1_model_carry", o_carry, q1[0].c);
`endif
                    if (out_ready) void'(q1.pop_front());
                end
            end
            if (in_valid && in_ready) q1.push_back(model(choice, i0, int'(shift_by)));
            if (out_valid0) begin
                if (q0.size() == 0) chk("p0_unexpected_valid", out_valid0, 1'b0);
                else begin
                    chk("p0_model_o", o0, q0[0].o);
                    chk("p0_model_zero", o_zero0, q0[0].z);
`ifdef SHROT_CARRY_EN
                    chk("p0_model_carry", o_carry0, q0[0].c);
`endif
                    if (out_ready0) void'(q0.pop_front());
                end
            end
            if (in_valid0 && in_ready0) q0.push_back(model(choice, i0, int'(shift_by)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] d, input logic [SHW-1:0] s);
        choice   = op;
        i0       = d;
        shift_by = s;
    endtask

    task automatic chk_out(input string nm, input logic [W-1:0] eo, input logic ez, input logic ec);
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_o"}, o, eo);
        chk({nm, "_zero"}, o_zero, ez);
`ifdef SHROT_CARRY_EN
        chk({nm, "_carry"}, o_carry, ec);
`else
        if (ec === 1'bx) chk({nm, "_carry_vec"}, ec, 1'b0);
`endif
    endtask

    logic [2:0]     bop[4] = '{3'b001, 3'b011, 3'b100, 3'b010};
    logic [W-1:0]   bd[4]  = '{16'h8001, 16'h0001, 16'h8000, 16'h00F0};
    logic [SHW-1:0] bs[4]  = '{4'd4, 4'd1, 4'd15, 4'd8};
    logic [W-1:0]   be[4]  = '{16'h0018, 16'h8000, 16'hFFFF, 16'h0000};
    logic           bz[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic           bc[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic [2:0]     sop[3] = '{3'b000, 3'b011, 3'b010};
    logic [W-1:0]   sd[3]  = '{16'h00FF, 16'h1234, 16'h0003};
    logic [SHW-1:0] ss[3]  = '{4'd4, 4'd4, 4'd1};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
        out_ready = 1'b1; out_ready0 = 1'b1;
        drive(3'b000, '0, '0);
        repeat (2) step();
        rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_valid", out_valid, 1'b0);
            chk("idle_o", o, 16'h0000);
            chk("idle_zero", o_zero, 1'b0);
            chk("idle_ready", in_ready, 1'b1);
        end

        // Single SLL: result visible on the 4th edge counting the accept edge.
        drive(3'b000, 16'h8001, 4'd1);
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) in_valid = 1'b0;
            if (k < 4) chk("lat_early_valid", out_valid, 1'b0);
        end
        chk_out("lat", 16'h0002, 1'b0, 1'b1);
        step();

        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                in_valid = 1'b1;
                drive(bop[c], bd[c], bs[c]);
            end else in_valid = 1'b0;
            step();
            if (c >= 3 && c <= 6) chk_out("b2b", be[c-3], bz[c-3], bc[c-3]);
            else if (c == 7) chk("b2b_drain_valid", out_valid, 1'b0);
        end

        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                in_valid = 1'b1;
                drive(sop[c], sd[c], ss[c]);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
            step();
        end
        for (int h = 0; h < 5; h++) begin
            chk("stall_ready", in_ready, 1'b0);
            chk_out("stall_hold", 16'h0FF0, 1'b0, 1'b0);
            step();
        end
        out_ready = 1'b1;
        chk_out("stall_release", 16'h0FF0, 1'b0, 1'b0);
        step();
        chk_out("drain1", 16'h4123, 1'b0, 1'b0);
        step();
        chk_out("drain2", 16'h0001, 1'b0, 1'b1);
        step();
        chk("drain_empty", out_valid, 1'b0);

        drive(3'b111, 16'hA5A5, 4'd7);
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) in_valid = 1'b0;
        end
        chk_out("reserved", 16'hA5A5, 1'b0, 1'b0);
        step();

        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            drive(3'b000, 16'h0001, SHW'(c + 1));
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_flush_valid", out_valid, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("post_rst_valid", out_valid, 1'b0);
        end

        in_valid0 = 1'b1;
        drive(3'b000, 16'h0001, 4'd15);
        step();
        chk("p0_sll_valid", out_valid0, 1'b1);
        chk("p0_sll_o", o0, 16'h8000);
        drive(3'b001, 16'h1234, 4'd8);
        step();
        in_valid0 = 1'b0;
        chk("p0_rol_valid", out_valid0, 1'b1);
        chk("p0_rol_o", o0, 16'h3412);
        step();
        chk("p0_drain_valid", out_valid0, 1'b0);

        step();
        chk("queue_p1_empty", q1.size(), 0);
        chk("queue_p0_empty", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_rotate_pipe.md
Name: shift_rotate_pipe

Overview:
- Next-generation shift/rotate unit: a WIDTH-bit logarithmic barrel shifter, split into pipeline stages, with a valid/ready handshake on both sides.
- Adds arithmetic shift right, a zero flag and optional carry-out to the existing SLL/ROL/SRL/ROR set.
- Sits between the operand register file and the writeback path.
- Sustains one operation per cycle when the downstream side is not stalling.

Parameters:
- WIDTH, 16, datapath width; power of two, minimum 4.
- PIPELINED, 1, 1 = register after every log stage; 0 = all log stages combinational with a single output register.
- SHW (localparam), log2(WIDTH), width of the shift amount.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit can accept an input this cycle.
- choice  in  3  operation select.
- i0  in  WIDTH  operand.
- shift_by  in  SHW  shift amount, 0..WIDTH-1.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- o  out  WIDTH  result.
- o_zero  out  1  result equals 0.
- o_carry  out  1  last bit shifted out; port exists only with SHROT_CARRY_EN.

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n=0 at a rising edge:
  - every stage valid bit, out_valid, o, o_zero and o_carry are cleared to 0;
  - in-flight operations are discarded, not completed.
- choice encoding:
  - 000 SLL, zero-fill from bit 0.
  - 001 ROL.
  - 010 SRL, zero-fill from the MSB.
  - 011 ROR.
  - 100 SRA, fill with i0[WIDTH-1].
  - 101..111 reserved: o = i0 unchanged, carry 0.
- Stages:
  - Stage k (k=0..SHW-1) shifts or rotates by 2^k when shift_by[k]=1; otherwise it passes the data through.
  - Each stage carries choice, the remaining shift_by bits and the carry bit alongside the data.
- Latency, accept to out_valid:
  - PIPELINED=1: SHW cycles (4 for WIDTH=16).
  - PIPELINED=0: 1 cycle.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready).
  - Stall (out_valid=1, out_ready=0): every stage holds, and o, o_zero, o_carry stay stable until consumed.
  - Bubbles propagate; they are not collapsed.
  - Accept and consume in the same cycle is legal; full throughput, one result per cycle.
- in_valid with in_ready=0 is ignored; the upstream side holds its inputs.
- o_zero = (o == 0), registered together with o.
- shift_by=0: o = i0 for every mode, carry 0.
- Ordering: results appear in accept order; nothing is dropped or duplicated except on reset.

Optional Feature:
- Macro SHROT_CARRY_EN.
- Defined: port o_carry exists. Its value is computed in stage 0 from i0 and the full shift_by = s, then pipelined with the data. For s>0:
  - SLL: i0[WIDTH-s].
  - SRL and SRA: i0[s-1].
  - ROL: o[0].
  - ROR: o[WIDTH-1].
  - s=0 or reserved choice: 0.
- Undefined: no o_carry port and no carry storage; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=0 for 10 cycles -> out_valid=0, o=0, o_zero=0 throughout; in_ready=1.
- WIDTH=16, PIPELINED=1, single op choice=000, i0=16'h8001, shift_by=1 -> exactly 4 cycles later out_valid=1, o=16'h0002, o_carry=1 (SHROT_CARRY_EN).
- Back-to-back ops every cycle with out_ready=1:
  - ROL 16'h8001 by 4 -> 16'h0018.
  - ROR 16'h0001 by 1 -> 16'h8000, o_carry=1.
  - SRA 16'h8000 by 15 -> 16'hFFFF.
  - SRL 16'h00F0 by 8 -> 16'h0000, o_zero=1.
  - Required: 4 consecutive valid results in order, no gaps.
- Stall: out_ready=0 for 5 cycles while a result is valid -> in_ready=0, o held unchanged; release out_ready -> remaining results drain in order, none lost or duplicated.
- Reserved choice=111 with i0=16'hA5A5, shift_by=7 -> o=16'hA5A5, o_carry=0. Then rst_n=0 for one cycle while 3 ops are in flight -> next cycle out_valid=0, and no stale results emerge afterwards.
- PIPELINED=0 build, SLL 16'h0001 by 15 -> o=16'h8000 one cycle after accept.
